// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM generator.
package pwm_pkg;

   localparam int DEF_WIDTH        = 8;
   localparam int DEF_PRESCALE_DIV = 4100;
   localparam int DEF_SAT_HIGH     = 250;

   // Smallest number of bits n with 2**n >= value.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: double-buffered duty, saturation/compare, polarity flop.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int   WIDTH    = DEF_WIDTH,
   parameter int   SAT_HIGH = DEF_SAT_HIGH,
   parameter logic POLARITY = 1'b0
) (
   input  logic             clock,
   input  logic             reset_InLow,
   input  logic             i_enable,
   input  logic             i_load,
   input  logic             i_transfer,
   input  logic [WIDTH-1:0] i_duty,
   input  logic [WIDTH-1:0] i_cnt,
   output logic             o_pwm
);

   logic [WIDTH-1:0] r_pending;
   logic [WIDTH-1:0] r_active;
   logic             r_pwm;
   logic             w_raw;

   // Raw active level from the duty currently in force and the shared period count.
   always_comb begin
      // NOTE: default assignment first so no path leaves w_raw unassigned (no latch).
      w_raw = 1'b0;
      if (int'(r_active) >= SAT_HIGH) begin
         w_raw = 1'b1;
      end else if (r_active != '0) begin
         w_raw = (i_cnt < r_active);
      end
   end

   // Duty double buffer; a load coinciding with a transfer goes straight to active.
   always_ff @(posedge clock or negedge reset_InLow) begin
      if (!reset_InLow) begin
         r_pending <= '0;
         r_active  <= '0;
         r_pwm     <= POLARITY;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         if (i_load) begin
            r_pending <= i_duty;
         end
         if (i_transfer) begin
            r_active <= i_load ? i_duty : r_pending;
         end
         r_pwm <= i_enable ? (w_raw ^ POLARITY) : POLARITY;
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: shared prescaler and period counter, phase-aligned compare channels.
module pwm_multichannel
   import pwm_pkg::*;
#(
   parameter int                    N_CHANNELS   = 4,
   parameter int                    WIDTH        = DEF_WIDTH,
   parameter int                    PRESCALE_DIV = DEF_PRESCALE_DIV,
   parameter int                    SAT_HIGH     = DEF_SAT_HIGH,
   parameter logic [N_CHANNELS-1:0] POLARITY     = {N_CHANNELS{1'b0}}
) (
   input  logic                        clock,
   input  logic                        reset_InLow,
   input  logic                        enable,
   input  logic                        load,
   input  logic [N_CHANNELS*WIDTH-1:0] duty_InBus,
   output logic [N_CHANNELS-1:0]       outPWM,
   output logic                        period_start
);

   localparam int               PS_W     = (PRESCALE_DIV > 1) ? clog2(PRESCALE_DIV) : 1;
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE_DIV - 1);
   // Last counter value of a period: MAX-1, so cnt never reaches MAX.
   localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);

   logic [PS_W-1:0]  r_presc;
   logic [WIDTH-1:0] r_cnt;
   logic             r_wrapped;
   logic             r_period_start;
   logic             w_tick;
   logic             w_boundary;
   logic             w_transfer;

   assign w_tick     = (r_presc == PS_LAST);
   assign w_boundary = w_tick && (r_cnt == CNT_LAST);
   // While disabled the channels track pending every cycle so re-enable uses the latest duty.
   assign w_transfer = w_boundary || !enable;

   // Prescaler, period counter and period-start strobe; all held cleared while disabled.
   // The strobe is delayed one clock after the wrap so it lines up with the first
   // registered output of the new period.
   always_ff @(posedge clock or negedge reset_InLow) begin
      if (!reset_InLow) begin
         r_presc        <= '0;
         r_cnt          <= '0;
         r_wrapped      <= 1'b0;
         r_period_start <= 1'b0;
      end else if (!enable) begin
         r_presc        <= '0;
         r_cnt          <= '0;
         r_wrapped      <= 1'b0;
         r_period_start <= 1'b0;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         end
         r_wrapped      <= w_boundary;
         r_period_start <= r_wrapped;
      end
   end

   assign period_start = r_period_start;

   for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
      pwm_channel #(
         .WIDTH    (WIDTH),
         .SAT_HIGH (SAT_HIGH),
         .POLARITY (POLARITY[k])
      ) u_ch (
         .clock       (clock),
         .reset_InLow (reset_InLow),
         .i_enable    (enable),
         .i_load      (load),
         .i_transfer  (w_transfer),
         .i_duty      (duty_InBus[k*WIDTH +: WIDTH]),
         .i_cnt       (r_cnt),
         .o_pwm       (outPWM[k])
      );
   end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel against a clock-count reference model.
module tb_pwm_multichannel;

   localparam int         NCH    = 2;
   localparam int         W      = 4;
   localparam int         DIV    = 2;
   localparam int         SAT    = 14;
   localparam int         MAXV   = 15;
   localparam int         PERIOD = MAXV * DIV;
   localparam logic [1:0] POL    = 2'b10;

   logic             clock;
   logic             reset_InLow;
   logic             enable;
   logic             load;
   logic [NCH*W-1:0] duty_InBus;
   logic [NCH-1:0]   outPWM;
   logic             period_start;

   pwm_multichannel #(
      .N_CHANNELS   (NCH),
      .WIDTH        (W),
      .PRESCALE_DIV (DIV),
      .SAT_HIGH     (SAT),
      .POLARITY     (POL)
   ) dut (
      .clock        (clock),
      .reset_InLow  (reset_InLow),
      .enable       (enable),
      .load         (load),
      .duty_InBus   (duty_InBus),
      .outPWM       (outPWM),
      .period_start (period_start)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   // Reference model: position within the period in clocks since enable.
   int         m_pos;
   int         m_act [NCH];
   int         m_pend[NCH];
   logic [1:0] m_pwm;
   logic       m_ps;
   logic       m_wrap_seen;

   // Measurement counters for the directed scenarios.
   int hi0, hi1, ps_cnt, first_ps, n_steps;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic raw_lvl(input int duty, input int cnt);
      if (duty >= SAT) return 1'b1;
      if (duty == 0)   return 1'b0;
      return (cnt < duty);
   endfunction

   function automatic logic [7:0] pack(input logic [3:0] d0, input logic [3:0] d1);
      return {d1, d0};
   endfunction

   task automatic model_reset();
      m_pos       = 0;
      m_pwm       = POL;
      m_ps        = 1'b0;
      m_wrap_seen = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         m_act[k]  = 0;
         m_pend[k] = 0;
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_edge();
      int d[NCH];
      for (int k = 0; k < NCH; k++) d[k] = int'(duty_InBus[k*W +: W]);
      if (!enable) begin
         m_pwm       = POL;
         m_ps        = 1'b0;
         m_wrap_seen = 1'b0;
         m_pos       = 0;
         for (int k = 0; k < NCH; k++) begin
            if (load) m_pend[k] = d[k];
            m_act[k] = m_pend[k];
         end
      end else begin
         for (int k = 0; k < NCH; k++) m_pwm[k] = raw_lvl(m_act[k], m_pos / DIV) ^ POL[k];
         m_ps        = m_wrap_seen;
         m_wrap_seen = (m_pos == PERIOD - 1);
         for (int k = 0; k < NCH; k++) begin
            if (m_wrap_seen) m_act[k] = load ? d[k] : m_pend[k];
            if (load) m_pend[k] = d[k];
         end
         m_pos = (m_pos + 1) % PERIOD;
      end
   endtask

   task automatic clear_meas();
      hi0 = 0; hi1 = 0; ps_cnt = 0; first_ps = 0; n_steps = 0;
   endtask

   // Apply inputs after a falling edge, step the model on the rising edge, compare on the next falling edge.
   task automatic step(input logic en, input logic ld, input logic [7:0] d);
      enable     = en;
      load       = ld;
      duty_InBus = d;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      load = 1'b0;
      check("out_pwm", 32'(outPWM), 32'(m_pwm));
      check("period_start", 32'(period_start), 32'(m_ps));
      n_steps++;
      if (outPWM[0]) hi0++;
      if (outPWM[1]) hi1++;
      if (period_start) begin
         ps_cnt++;
         if (first_ps == 0) first_ps = n_steps;
      end
   endtask

   // Run n enabled clocks, optionally loading ld_val on clock number ld_at (1-based).
   task automatic en_run(input int n, input int ld_at, input logic [7:0] ld_val);
      for (int i = 1; i <= n; i++) begin
         if (i == ld_at) step(1'b1, 1'b1, ld_val);
         else            step(1'b1, 1'b0, 8'($urandom));
      end
   endtask

   int ext_d [4] = '{0, 14, 15, 13};
   int ext_hi[4] = '{0, 30, 30, 26};

   initial begin
      reset_InLow = 1'b0;
      enable      = 1'b0;
      load        = 1'b0;
      duty_InBus  = '0;
      model_reset();
      clear_meas();
      repeat (2) @(negedge clock);
      check("reset_pwm", 32'(outPWM), 32'(2'b10));
      check("reset_ps", 32'(period_start), 0);
      reset_InLow = 1'b1;

      // Basic duty: 5 on both channels, loaded while disabled.
      step(1'b0, 1'b1, pack(4'd5, 4'd5));
      clear_meas();
      en_run(PERIOD, 0, 8'h00);
      check("basic_hi0", hi0, 10);
      check("basic_hi1", hi1, 20);
      check("basic_no_ps_first", ps_cnt, 0);
      clear_meas();
      en_run(PERIOD, 0, 8'h00);
      check("basic_hi0_p2", hi0, 10);
      check("basic_ps_count", ps_cnt, 1);
      check("basic_ps_pos", first_ps, 1);

      // Extremes: zero, saturation threshold, MAX and just below threshold.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, pack(4'(ext_d[i]), 4'(ext_d[i])));
         clear_meas();
         en_run(PERIOD, 0, 8'h00);
         check("extreme_hi0", hi0, ext_hi[i]);
         check("extreme_hi1", hi1, PERIOD - ext_hi[i]);
      end

      // Shadowing: two loads within a period, the last one wins at the next period.
      step(1'b0, 1'b1, pack(4'd5, 4'd5));
      clear_meas();
      for (int i = 1; i <= PERIOD; i++) begin
         if (i == 7)       step(1'b1, 1'b1, pack(4'd9, 4'd9));
         else if (i == 17) step(1'b1, 1'b1, pack(4'd7, 4'd7));
         else              step(1'b1, 1'b0, 8'($urandom));
      end
      check("shadow_cur", hi0, 10);
      clear_meas();
      en_run(PERIOD, 0, 8'h00);
      check("shadow_next", hi0, 14);

      // Boundary collision: load in the wrap cycle takes effect for the starting period.
      step(1'b0, 1'b1, pack(4'd5, 4'd5));
      clear_meas();
      en_run(PERIOD, PERIOD, pack(4'd3, 4'd3));
      check("collide_old", hi0, 10);
      clear_meas();
      en_run(PERIOD, 0, 8'h00);
      check("collide_new", hi0, 6);

      // Enable drop mid-period, then re-enable from cnt=0 without an early strobe.
      en_run(5, 0, 8'h00);
      step(1'b0, 1'b0, 8'($urandom));
      check("en_drop_pwm", 32'(outPWM), 32'(2'b10));
      clear_meas();
      en_run(PERIOD, 0, 8'h00);
      check("reen_no_ps", ps_cnt, 0);
      check("reen_hi0", hi0, 6);
      clear_meas();
      en_run(PERIOD, 0, 8'h00);
      check("reen_ps_pos", first_ps, 1);

      // Asynchronous reset mid-period while ch0 is driving active.
      step(1'b0, 1'b1, pack(4'd5, 4'd5));
      en_run(3, 0, 8'h00);
      #3;
      reset_InLow = 1'b0;
      #1;
      check("mid_reset_pwm", 32'(outPWM), 32'(2'b10));
      check("mid_reset_ps", 32'(period_start), 0);
      @(negedge clock);
      reset_InLow = 1'b1;
      model_reset();
      clear_meas();
      en_run(PERIOD, 1, pack(4'd5, 4'd5));
      check("post_reset_hi0", hi0, 0);
      check("post_reset_no_ps", ps_cnt, 0);
      clear_meas();
      en_run(PERIOD, 0, 8'h00);
      check("post_reset_hi0_p2", hi0, 10);
      check("post_reset_ps_pos", first_ps, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(15) != 0), ($urandom_range(7) == 0), 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
